sync_fifo_thr: RTL and testbench

Single-clock, parametrised successor to the dual-clock async_fifo. Keeps the same write/read handshake (winc/rinc, wfull/rempty) and show-ahead read data. Adds configurable almost-full and almost-empty thresholds and an occupancy count. Used wherever producer and consumer share one clock domain, so no pointer synchronisers are needed.

---
 rtl/sync_fifo_pkg.sv | 14 +
 rtl/sync_fifo_mem.sv | 24 ++
 rtl/sync_fifo_thr.sv | 91 +++++++++
 tb/tb_sync_fifo_thr.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and the threshold legality check for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;

  // Almost-full must lie in 1..DEPTH and almost-empty in 0..DEPTH-1.
  function automatic bit thr_legal(input int asize, input int afull, input int aempty);
    int depth;
    depth = 1 << asize;
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE register array: synchronous write, asynchronous (show-ahead) read, no reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with almost-full/almost-empty thresholds and occupancy count.
// Optional sticky overflow/underflow outputs when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_thr
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE      = DEF_DSIZE,
  parameter int ASIZE      = DEF_ASIZE,
  parameter int AFULL_THR  = 14,
  parameter int AEMPTY_THR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [ASIZE:0]   count
);

  localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] AFULL_C  = AFULL_THR[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_THR[ASIZE:0];

  if (!thr_legal(ASIZE, AFULL_THR, AEMPTY_THR)) begin : g_bad_thr
    $error("sync_fifo_thr: AFULL_THR=%0d or AEMPTY_THR=%0d out of range for ASIZE=%0d",
           AFULL_THR, AEMPTY_THR, ASIZE);
  end

  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic           wr_ok;
  logic           rd_ok;

  // Flags derive from registered pointers/count only; requests never reach them combinationally.
  assign rempty        = (wptr == rptr);
  assign wfull         = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign walmost_full  = (count >= AFULL_C);
  assign ralmost_empty = (count <= AEMPTY_C);

  assign wr_ok = winc && !wfull;
  assign rd_ok = rinc && !rempty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + ONE;
      if (rd_ok) rptr <= rptr + ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end
`endif

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok && !rst),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed bench for sync_fifo_thr (DEPTH=16, AFULL_THR=14, AEMPTY_THR=2).
module tb_sync_fifo_thr;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic       walmost_full;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] v;

  always #5 clk = ~clk;

  sync_fifo_thr #(
    .DSIZE      (8),
    .ASIZE      (4),
    .AFULL_THR  (14),
    .AEMPTY_THR (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .rinc          (rinc),
    .rdata         (rdata),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
`ifdef SYNC_FIFO_ERR_EN
    .overflow      (overflow),
    .underflow     (underflow),
`endif
    .count         (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int n);
    chk({tag, "_count"}, 32'(count), 32'(n));
    chk({tag, "_rempty"}, 32'(rempty), 32'(n == 0));
    chk({tag, "_wfull"}, 32'(wfull), 32'(n == 16));
    chk({tag, "_aempty"}, 32'(ralmost_empty), 32'(n <= 2));
    chk({tag, "_afull"}, 32'(walmost_full), 32'(n >= 14));
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    #1;
    step(); step();
    rst = 1'b0;
    chk_flags("reset", 0);
`ifdef SYNC_FIFO_ERR_EN
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_underflow", 32'(underflow), 32'd0);
`endif

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(i);
      step();
      chk_flags("fill", i + 1);
      chk("fill_head", 32'(rdata), 32'h00);
    end
    wdata = 8'hFF;
    step();
    winc = 1'b0;
    chk_flags("over", 16);
`ifdef SYNC_FIFO_ERR_EN
    chk("overflow_set", 32'(overflow), 32'd1);
`endif

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(rdata), 32'(i));
      rinc = 1'b1;
      step();
      chk_flags("drain", 15 - i);
    end
    step();
    rinc = 1'b0;
    chk_flags("under", 0);
`ifdef SYNC_FIFO_ERR_EN
    chk("underflow_set", 32'(underflow), 32'd1);
    chk("overflow_sticky", 32'(overflow), 32'd1);
`endif

    // Preload 5, then 40 cycles of simultaneous write/read
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1; wdata = 8'($urandom);
      q.push_back(wdata);
      step();
    end
    chk_flags("preload", 5);
    rinc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wdata = 8'($urandom);
      chk("stream_data", 32'(rdata), 32'(q[0]));
      v = q.pop_front();
      q.push_back(wdata);
      step();
      chk("stream_count", 32'(count), 32'd5);
    end
    rinc = 1'b0;

    // Top up to full
    for (int i = 0; i < 11; i++) begin
      wdata = 8'($urandom);
      q.push_back(wdata);
      step();
    end
    chk_flags("refull", 16);

    // Simultaneous request at full: only the read goes through
    wdata = 8'h77; rinc = 1'b1;
    chk("full_both_head", 32'(rdata), 32'(q[0]));
    v = q.pop_front();
    step();
    winc = 1'b0; rinc = 1'b0;
    chk_flags("full_both", 15);
    chk("full_both_next", 32'(rdata), 32'(q[0]));

    while (q.size() > 0) begin
      chk("drain2_data", 32'(rdata), 32'(q[0]));
      v = q.pop_front();
      rinc = 1'b1;
      step();
    end
    rinc = 1'b0;
    chk_flags("drain2", 0);

    // Simultaneous request at empty: only the write goes through
    winc = 1'b1; rinc = 1'b1; wdata = 8'h3C;
    step();
    winc = 1'b0; rinc = 1'b0;
    chk_flags("empty_both", 1);
    chk("empty_both_data", 32'(rdata), 32'h3C);

    // Reset at count 9 discards everything; requests during rst are ignored
    winc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'(8'h40 + i);
      step();
    end
    chk_flags("pre_rst", 9);
    rst = 1'b1; rinc = 1'b1; wdata = 8'hEE;
    step();
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    chk_flags("mid_rst", 0);
`ifdef SYNC_FIFO_ERR_EN
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_underflow", 32'(underflow), 32'd0);
`endif
    winc = 1'b1; wdata = 8'hA5;
    step();
    winc = 1'b0;
    chk_flags("post_rst_wr", 1);
    chk("post_rst_data", 32'(rdata), 32'hA5);
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    chk_flags("post_rst_rd", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
